// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write counters for long-latency
// producers (loads, mul/div). Publishes a registered pending bitmap and busy
// flag, a combinational issue-ready and decode-stall, and a sticky underflow
// error. Register 0 is hard-wired and never tracked.
//
// Handshake: an issue is taken on a cycle where iss_valid && iss_ready are
// both high and iss_rd != 0. When iss_ready is low, the producer holds the op
// and nothing is recorded. Completions have no back-pressure and are always
// consumed in the cycle they are presented.
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_enable,
   output logic                scoreboard_enable,
   input  logic                iss_valid,
   input  logic [4:0]          iss_rd,
   output logic                iss_ready,
   input  logic                cmp0_valid,
   input  logic [4:0]          cmp0_rd,
   input  logic                cmp1_valid,
   input  logic [4:0]          cmp1_rd,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   output logic [NUM_REGS-1:0] reg_write_bitmap,
   output logic                sb_stall,
   output logic                busy,
   output logic                err_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] bitmap_q, bitmap_d;
   logic                busy_q, busy_d;
   logic                en_q, en_d;
   logic                err_q, err_d;
   logic                iss_accept;
   logic                underflow_hit;
   logic                rs1_pend, rs2_pend;

   // Issue readiness uses the pre-update count of the named destination.
   // rd 0 and any index beyond the tracked range are never back-pressured.
   always_comb begin
      iss_ready = 1'b1;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (iss_rd == 5'(r) && cnt_q[r] == CNT_MAX) begin
            iss_ready = 1'b0;
         end
      end
   end

   assign iss_accept = iss_valid && iss_ready && (iss_rd != 5'd0);

   // Net counter update: +1 for an accepted issue, -1 per completion port
   // naming the register. A net below zero clamps to 0 and flags underflow.
   // Overflow cannot happen because iss_ready gates the increment.
   always_comb begin
      logic [CNT_W:0] up;
      logic [1:0]     down;
      underflow_hit = 1'b0;
      up            = '0;
      down          = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r != 0) begin
            up   = {1'b0, cnt_q[r]}
                 + {{CNT_W{1'b0}}, (iss_accept && iss_rd == 5'(r))};
            down = {1'b0, (cmp0_valid && cmp0_rd == 5'(r))}
                 + {1'b0, (cmp1_valid && cmp1_rd == 5'(r))};
            if (up < (CNT_W+1)'(down)) begin
               cnt_d[r]      = '0;
               underflow_hit = 1'b1;
            end else begin
               cnt_d[r] = CNT_W'(up - (CNT_W+1)'(down));
            end
         end else begin
            cnt_d[r] = '0;
         end
      end
   end

   // Registered views derive from the next-state counters so they line up
   // with the counters themselves one cycle after the event.
   always_comb begin
      bitmap_d = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         bitmap_d[r] = (cnt_d[r] != '0);
      end
      busy_d = |bitmap_d;
      en_d   = cfg_enable;
      err_d  = err_q | underflow_hit;
   end

   // State registers; reset wins over any same-cycle issue or completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         bitmap_q <= '0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         bitmap_q <= bitmap_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         err_q    <= err_d;
      end
   end

   // Decode stall: an ID source is pending in the registered bitmap. Only
   // the stall is gated by enable; tracking keeps running regardless.
   always_comb begin
      rs1_pend = 1'b0;
      rs2_pend = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (id_rs1 == 5'(r) && bitmap_q[r]) rs1_pend = 1'b1;
         if (id_rs2 == 5'(r) && bitmap_q[r]) rs2_pend = 1'b1;
      end
      sb_stall = en_q && (rs1_pend || rs2_pend);
   end

   assign reg_write_bitmap  = bitmap_q;
   assign busy              = busy_q;
   assign scoreboard_enable = en_q;
   assign err_underflow     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed scenarios followed by random
// traffic, checked against an integer-count reference model through an
// expected-response queue drained by an independent monitor.
module tb_reg_scoreboard;

   logic        clk;
   logic        rst;
   logic        cfg_enable;
   logic        scoreboard_enable;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        cmp0_valid;
   logic [4:0]  cmp0_rd;
   logic        cmp1_valid;
   logic [4:0]  cmp1_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [31:0] reg_write_bitmap;
   logic        sb_stall;
   logic        busy;
   logic        err_underflow;

   reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_enable        (cfg_enable),
      .scoreboard_enable (scoreboard_enable),
      .iss_valid         (iss_valid),
      .iss_rd            (iss_rd),
      .iss_ready         (iss_ready),
      .cmp0_valid        (cmp0_valid),
      .cmp0_rd           (cmp0_rd),
      .cmp1_valid        (cmp1_valid),
      .cmp1_rd           (cmp1_rd),
      .id_rs1            (id_rs1),
      .id_rs2            (id_rs2),
      .reg_write_bitmap  (reg_write_bitmap),
      .sb_stall          (sb_stall),
      .busy              (busy),
      .err_underflow     (err_underflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] bm;
      logic        busy;
      logic        en;
      logic        err;
      logic        rdy;
      logic        stall;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model: plain integer counts, max count 3
   int m_cnt[32];
   bit m_en;
   bit m_err;

   function automatic exp_t model_outputs();
      exp_t e;
      e.bm = '0;
      for (int r = 1; r < 32; r++) e.bm[r] = (m_cnt[r] > 0);
      e.busy  = (e.bm != 0);
      e.en    = m_en;
      e.err   = m_err;
      e.rdy   = (iss_rd == 0) || (m_cnt[iss_rd] < 3);
      e.stall = m_en && ((id_rs1 != 0 && m_cnt[id_rs1] > 0) ||
                         (id_rs2 != 0 && m_cnt[id_rs2] > 0));
      return e;
   endfunction

   task automatic model_step();
      int delta[32];
      int v;
      if (rst) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         m_en  = 0;
         m_err = 0;
         return;
      end
      for (int r = 0; r < 32; r++) delta[r] = 0;
      if (iss_valid && iss_rd != 0 && m_cnt[iss_rd] < 3) delta[iss_rd] += 1;
      if (cmp0_valid && cmp0_rd != 0) delta[cmp0_rd] -= 1;
      if (cmp1_valid && cmp1_rd != 0) delta[cmp1_rd] -= 1;
      for (int r = 1; r < 32; r++) begin
         v = m_cnt[r] + delta[r];
         if (v < 0) begin
            v = 0;
            m_err = 1;
         end
         m_cnt[r] = v;
      end
      m_en = cfg_enable;
   endtask

   // driver: apply inputs just after an edge, push expected outputs for
   // this cycle, then advance the model across the next edge
   task automatic cycle(input bit r, input bit en,
                        input bit iv, input int ird,
                        input bit c0v, input int c0r,
                        input bit c1v, input int c1r,
                        input int rs1, input int rs2);
      rst        = r;
      cfg_enable = en;
      iss_valid  = iv;
      iss_rd     = 5'(ird);
      cmp0_valid = c0v;
      cmp0_rd    = 5'(c0r);
      cmp1_valid = c1v;
      cmp1_rd    = 5'(c1r);
      id_rs1     = 5'(rs1);
      id_rs2     = 5'(rs2);
      exp_q.push_back(model_outputs());
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // monitor / scoreboard: every cycle presents outputs; compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bitmap",    reg_write_bitmap,          e.bm);
            check("busy",      32'(busy),                 32'(e.busy));
            check("sb_enable", 32'(scoreboard_enable),    32'(e.en));
            check("err_uflow", 32'(err_underflow),        32'(e.err));
            check("iss_ready", 32'(iss_ready),            32'(e.rdy));
            check("sb_stall",  32'(sb_stall),             32'(e.stall));
         end
      end
   end

   initial begin
      // initial reset edge: DUT state is unknown before it, so no expectation
      rst = 1; cfg_enable = 0; iss_valid = 1; iss_rd = 5;
      cmp0_valid = 0; cmp0_rd = 0; cmp1_valid = 0; cmp1_rd = 0;
      id_rs1 = 0; id_rs2 = 0;
      @(posedge clk);
      model_step();
      #1;

      // reset held with an issue pending
      cycle(1, 0, 1, 5, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 5, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // issue rd 7, hold rs2 = 7, complete on port 0
      cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 7);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 7);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 7);
      cycle(0, 1, 0, 0, 1, 7, 0, 0, 0, 7);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 7);

      // saturation on rd 3, then a dual completion
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 3, 0, 0, 0, 0, 3, 0);
      cycle(0, 1, 1, 3, 1, 3, 1, 3, 3, 0);
      cycle(0, 1, 1, 3, 0, 0, 0, 0, 3, 0);
      cycle(0, 1, 0, 0, 1, 3, 1, 3, 3, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 3, 0);

      // simultaneous issue and completion on rd 9
      cycle(0, 1, 1, 9, 0, 0, 0, 0, 9, 9);
      cycle(0, 1, 1, 9, 0, 0, 1, 9, 9, 9);
      cycle(0, 1, 0, 0, 1, 9, 0, 0, 9, 9);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 9, 9);

      // underflow on rd 12, sticky afterwards
      cycle(0, 1, 0, 0, 1, 12, 0, 0, 12, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 12, 0);
      cycle(0, 1, 1, 12, 0, 0, 0, 0, 12, 0);

      // register 0 ignored, then enable gating on rd 4
      cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 1, 12, 0, 0, 0, 0);
      cycle(0, 0, 1, 4, 0, 0, 1, 0, 4, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 4, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 4, 0);
      cycle(0, 1, 0, 0, 1, 4, 0, 0, 4, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 4, 0);

      // reset clears the sticky error
      cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // random traffic over a small register window to hit saturation
      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 9) < 8,
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
               $urandom_range(0, 9) < 4,  int'($urandom_range(0, 7)),
               $urandom_range(0, 9) < 3,  int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
